// File: rtl/instr_feeder.sv
// instr_feeder: program-memory sequencer driving DIN/Run of processador_multiciclo.
// Optional single-step mode is enabled by defining FEEDER_SINGLE_STEP_EN.
module instr_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter logic [2:0]  MVI_OPCODE = 3'b001,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W:0]   Length,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [15:0]       WrData,
  input  logic              Step,
  input  logic              Done,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        InstrCount
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_PAUSE,
    S_HALT,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   pc_q, pc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              mvi_q, mvi_d;
  logic [15:0]       mem_q [DEPTH];

  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W+1:0] pc_inc1;
  logic [ADDR_W+1:0] pc_next;
  logic [15:0]       word_cur;
  logic [15:0]       word_imm;
  logic              fetch_is_mvi;
  logic              mvi_fault;
  logic              prog_open;
  logic              step_rise;

  assign len_eff      = (Length > DEPTH_L) ? DEPTH_L : Length;
  assign pc_inc1      = {1'b0, pc_q} + 1'b1;
  assign pc_next      = {1'b0, pc_q} + (mvi_q ? (ADDR_W + 2)'(2) : (ADDR_W + 2)'(1));
  assign word_cur     = mem_q[pc_q[ADDR_W-1:0]];
  assign word_imm     = mem_q[pc_inc1[ADDR_W-1:0]];
  assign fetch_is_mvi = (word_cur[8:6] == MVI_OPCODE);
  // An mvi whose immediate would lie past the program end cannot be issued.
  assign mvi_fault    = fetch_is_mvi && (pc_inc1 >= {1'b0, len_eff});
  assign prog_open    = (state_q == S_IDLE) || (state_q == S_HALT);

`ifdef FEEDER_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) step_q <= 1'b0;
    else         step_q <= Step;
  end

  assign step_rise = Step && !step_q;
`else
  logic unused_step;
  assign unused_step = Step;
  assign step_rise   = 1'b0;
`endif

  // NOTE: program memory has no reset; contents survive Resetn and only WrEn changes them.
  always_ff @(posedge Clock) begin
    if (WrEn && prog_open) mem_q[WrAddr] <= WrData;
  end

  // NOTE: every sequential assignment is non-blocking so all flops update from pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      mvi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      mvi_q   <= mvi_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    mvi_d   = mvi_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          if (len_eff == '0) begin
            state_d = S_HALT;
          end else begin
            pc_d    = '0;
            cnt_d   = '0;
            wdog_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        mvi_d   = fetch_is_mvi;
        wdog_d  = '0;
        state_d = mvi_fault ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        if (Done) begin
          pc_d   = pc_next[ADDR_W:0];
          cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          wdog_d = '0;
          if (pc_next >= {1'b0, len_eff}) begin
            state_d = S_HALT;
          end else begin
`ifdef FEEDER_SINGLE_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_FETCH;
`endif
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WD_W'(TIMEOUT - 1)) state_d = S_FAULT;
        end
      end
      S_PAUSE: begin
        if (step_rise) state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    DIN    = '0;
    Run    = 1'b0;
    Busy   = 1'b0;
    Halted = 1'b0;
    Error  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        Busy  = 1'b1;
        DIN   = word_cur;
        Run   = !mvi_fault;
        Error = mvi_fault;
      end
      S_EXEC: begin
        Busy = 1'b1;
        DIN  = mvi_q ? word_imm : word_cur;
      end
      S_PAUSE: begin
        Busy = 1'b1;
        DIN  = word_cur;
      end
      S_HALT:  Halted = 1'b1;
      S_FAULT: Error  = 1'b1;
      default: begin
        DIN = '0;
      end
    endcase
  end

  assign PC         = pc_q[ADDR_W-1:0];
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: cycle-vector table plus directed corner-case sequences.
module tb_instr_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  len_i = 5'd0;
  logic        wr_en_i = 1'b0;
  logic [3:0]  wr_addr_i = 4'd0;
  logic [15:0] wr_data_i = 16'h0;
  logic        step_i = 1'b0;
  logic        done_i = 1'b0;
  logic [15:0] din_o;
  logic        run_o, busy_o, halted_o, error_o;
  logic [3:0]  pc_o;
  logic [7:0]  cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_feeder dut (
    .Clock(clk), .Resetn(rst_n), .Start(start_i), .Length(len_i),
    .WrEn(wr_en_i), .WrAddr(wr_addr_i), .WrData(wr_data_i), .Step(step_i),
    .Done(done_i), .DIN(din_o), .Run(run_o), .Busy(busy_o), .Halted(halted_o),
    .Error(error_o), .PC(pc_o), .InstrCount(cnt_o)
  );

  typedef struct {
    logic        start;
    logic [4:0]  len;
    logic        done;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        e_run;
    logic [15:0] e_din;
    logic        e_busy;
    logic        e_halt;
    logic        e_err;
    logic [3:0]  e_pc;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t v(input logic s, input logic [4:0] l, input logic d,
                             input logic we, input logic [3:0] wa, input logic [15:0] wd,
                             input logic r, input logic [15:0] din, input logic b,
                             input logic h, input logic e, input logic [3:0] p,
                             input logic [7:0] c);
    vec_t x;
    x.start = s; x.len = l; x.done = d; x.we = we; x.wa = wa; x.wd = wd;
    x.e_run = r; x.e_din = din; x.e_busy = b; x.e_halt = h; x.e_err = e;
    x.e_pc = p; x.e_cnt = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs away from the active edge, then settles before sampling.
  task automatic drive(input logic s, input logic [4:0] l, input logic d, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd, input logic stp);
    @(negedge clk);
    start_i = s; len_i = l; done_i = d; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    step_i = stp;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_i = 1'b0; done_i = 1'b0; wr_en_i = 1'b0; step_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Preload, run mvi+plain program, ignore Done in HALT, Length=0 restart, dropped EXEC write.
    vecs[0]  = v(1'b0, 5'd3, 1'b0, 1'b1, 4'd0, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[1]  = v(1'b0, 5'd3, 1'b0, 1'b1, 4'd1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[2]  = v(1'b0, 5'd3, 1'b0, 1'b1, 4'd2, 16'h0008, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[3]  = v(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[4]  = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[5]  = v(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[6]  = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
    vecs[7]  = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
    vecs[8]  = v(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
    vecs[9]  = v(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd3, 8'd2);
    vecs[10] = v(1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd3, 8'd2);
    vecs[11] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd3, 8'd2);
    vecs[12] = v(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd3, 8'd2);
    vecs[13] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[14] = v(1'b0, 5'd3, 1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[15] = v(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
    vecs[16] = v(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
    vecs[17] = v(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd3, 8'd2);
    vecs[18] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[19] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[20] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[21] = v(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    vecs[22] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);
    vecs[23] = v(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].start, vecs[i].len, vecs[i].done, vecs[i].we, vecs[i].wa, vecs[i].wd, 1'b0);
      check($sformatf("vec%0d.run", i),    32'(run_o),    32'(vecs[i].e_run));
      check($sformatf("vec%0d.din", i),    32'(din_o),    32'(vecs[i].e_din));
      check($sformatf("vec%0d.busy", i),   32'(busy_o),   32'(vecs[i].e_busy));
      check($sformatf("vec%0d.halted", i), 32'(halted_o), 32'(vecs[i].e_halt));
      check($sformatf("vec%0d.error", i),  32'(error_o),  32'(vecs[i].e_err));
      check($sformatf("vec%0d.pc", i),     32'(pc_o),     32'(vecs[i].e_pc));
      check($sformatf("vec%0d.count", i),  32'(cnt_o),    32'(vecs[i].e_cnt));
    end

    // Asynchronous reset mid-EXEC at PC=2: outputs drop without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.run",   32'(run_o),    32'd0);
    check("async_rst.busy",  32'(busy_o),   32'd0);
    check("async_rst.pc",    32'(pc_o),     32'd0);
    check("async_rst.count", 32'(cnt_o),    32'd0);
    check("async_rst.din",   32'(din_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Watchdog: mvi at PC 0, Done never comes.
    drive(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("wd.fetch_run", 32'(run_o), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
      check($sformatf("wd.exec%0d.busy", k),  32'(busy_o),  32'd1);
      check($sformatf("wd.exec%0d.error", k), 32'(error_o), 32'd0);
      check($sformatf("wd.exec%0d.run", k),   32'(run_o),   32'd0);
    end
    drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("wd.fault.error", 32'(error_o), 32'd1);
    check("wd.fault.busy",  32'(busy_o),  32'd0);
    check("wd.fault.pc",    32'(pc_o),    32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
      check($sformatf("wd.sticky%0d.error", k), 32'(error_o), 32'd1);
      check($sformatf("wd.sticky%0d.run", k),   32'(run_o),   32'd0);
      check($sformatf("wd.sticky%0d.busy", k),  32'(busy_o),  32'd0);
    end
    drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("wd.still_fault", 32'(error_o), 32'd1);
    do_reset();
    #1;
    check("wd.cleared.error", 32'(error_o), 32'd0);

    // mvi at the last program word: FAULT at FETCH, Run never raised.
    drive(1'b1, 5'd1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    drive(1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("mvi_last.fetch_run",   32'(run_o),   32'd0);
    check("mvi_last.fetch_error", 32'(error_o), 32'd1);
    drive(1'b0, 5'd1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("mvi_last.run",   32'(run_o),   32'd0);
    check("mvi_last.error", 32'(error_o), 32'd1);
    check("mvi_last.pc",    32'(pc_o),    32'd0);
    do_reset();

    // Length clamp to 16 words, plus write and Start in the same cycle.
    for (int i = 1; i < 16; i++) drive(1'b0, 5'd31, 1'b0, 1'b1, 4'(i), 16'h0008, 1'b0);
    drive(1'b1, 5'd31, 1'b0, 1'b1, 4'd0, 16'h0123, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd31, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
      check($sformatf("clamp%0d.run", i), 32'(run_o), 32'd1);
      check($sformatf("clamp%0d.pc", i),  32'(pc_o),  32'(i));
      check($sformatf("clamp%0d.din", i), 32'(din_o), (i == 0) ? 32'h0123 : 32'h0008);
      drive(1'b0, 5'd31, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    end
    drive(1'b0, 5'd31, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("clamp.halted", 32'(halted_o), 32'd1);
    check("clamp.count",  32'(cnt_o),    32'd16);
    check("clamp.busy",   32'(busy_o),   32'd0);
    check("clamp.pc",     32'(pc_o),     32'd0);

`ifdef FEEDER_SINGLE_STEP_EN
    // Single step over mem = {0x0123, 0x0008, 0x0008}.
    do_reset();
    drive(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("ss.fetch0.run", 32'(run_o), 32'd1);
    drive(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 3; w++) begin
        drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, (w == 2) ? 1'b1 : 1'b0);
        check($sformatf("ss%0d.pause%0d.busy", k, w), 32'(busy_o), 32'd1);
        check($sformatf("ss%0d.pause%0d.run", k, w),  32'(run_o),  32'd0);
        check($sformatf("ss%0d.pause%0d.pc", k, w),   32'(pc_o),   32'(k + 1));
        check($sformatf("ss%0d.pause%0d.din", k, w),  32'(din_o),  32'h0008);
      end
      drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
      check($sformatf("ss%0d.fetch.run", k), 32'(run_o), 32'd1);
      drive(1'b0, 5'd3, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    end
    drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("ss.halted", 32'(halted_o), 32'd1);
    check("ss.count",  32'(cnt_o),    32'd3);
    drive(1'b0, 5'd3, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("ss.halted_hold", 32'(halted_o), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
